// File: rtl/decode_stage_if.sv
// ----------------------------------------------------------------------------
// decode_stage_if
// Bundles the fetch-side and issue-side handshakes plus all decoded fields of
// the Coast decode stage.
//   slave  : decode stage side (takes flush/instruction/ready, drives fields)
//   master : environment side (fetch + issue logic)
// Signals:
//   flush_i, inst_i[31:0], inst_valid_i, inst_ready_o   fetch side
//   dec_valid_o, dec_ready_i                            issue side
//   alu_o, pc_o, reg_o, imm_o, mem_o                    control fields
//   reg_addr_1..4_o, ram_addr_o, imm_data_1/2_o         operands
//   npu_ram_addr_o, npu_w_reg_addr_o                    NPU fields
//   illegal_o, hazard_o, count_o, level_o               status
// ----------------------------------------------------------------------------
interface decode_stage_if #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
);
   logic                   flush_i;
   logic [31:0]            inst_i;
   logic                   inst_valid_i;
   logic                   inst_ready_o;
   logic                   dec_valid_o;
   logic                   dec_ready_i;
   logic [7:0]             alu_o;
   logic [1:0]             pc_o;
   logic [1:0]             reg_o;
   logic                   imm_o;
   logic                   mem_o;
   logic [4:0]             reg_addr_1_o;
   logic [4:0]             reg_addr_2_o;
   logic [4:0]             reg_addr_3_o;
   logic [4:0]             reg_addr_4_o;
   logic [15:0]            ram_addr_o;
   logic [7:0]             imm_data_1_o;
   logic [7:0]             imm_data_2_o;
   logic [7:0]             npu_ram_addr_o;
   logic [4:0]             npu_w_reg_addr_o;
   logic                   illegal_o;
   logic                   hazard_o;
   logic [CNT_W-1:0]       count_o;
   logic [$clog2(DEPTH):0] level_o;

   modport slave (
      input  flush_i, inst_i, inst_valid_i, dec_ready_i,
      output inst_ready_o, dec_valid_o, alu_o, pc_o, reg_o, imm_o, mem_o,
             reg_addr_1_o, reg_addr_2_o, reg_addr_3_o, reg_addr_4_o,
             ram_addr_o, imm_data_1_o, imm_data_2_o, npu_ram_addr_o,
             npu_w_reg_addr_o, illegal_o, hazard_o, count_o, level_o
   );

   modport master (
      output flush_i, inst_i, inst_valid_i, dec_ready_i,
      input  inst_ready_o, dec_valid_o, alu_o, pc_o, reg_o, imm_o, mem_o,
             reg_addr_1_o, reg_addr_2_o, reg_addr_3_o, reg_addr_4_o,
             ram_addr_o, imm_data_1_o, imm_data_2_o, npu_ram_addr_o,
             npu_w_reg_addr_o, illegal_o, hazard_o, count_o, level_o
   );
endinterface

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// Coast CPU instruction decode: each accepted 32-bit word is decoded into the
// field set and queued in a DEPTH-entry FIFO (valid/ready on both sides).
// Adds illegal-opcode detection, synchronous flush, a saturating count of
// accepted instructions and an optional read-after-write hazard flag.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    decode_stage_if.slave (handshakes, decoded fields, status)
// Parameters: DEPTH (power of two, >= 2), CNT_W (counter width)
// Optional feature: define DECODE_HAZARD_EN to enable RAW hazard tracking;
// otherwise hazard_o is tied to 0.
// ----------------------------------------------------------------------------
module decode_stage #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   decode_stage_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   // Coast shared opcode / register constants
   localparam logic [7:0] OP_ADD     = 8'h01;
   localparam logic [7:0] OP_SUB     = 8'h02;
   localparam logic [7:0] OP_MUL     = 8'h03;
   localparam logic [7:0] OP_DIV     = 8'h04;
   localparam logic [7:0] OP_AND     = 8'h05;
   localparam logic [7:0] OP_OR      = 8'h06;
   localparam logic [7:0] OP_NOT     = 8'h07;
   localparam logic [7:0] OP_RSHIFT  = 8'h08;
   localparam logic [7:0] OP_LSHIFT  = 8'h09;
   localparam logic [7:0] OP_MOVE    = 8'h0A;
   localparam logic [7:0] OP_MOVEIN  = 8'h0B;
   localparam logic [7:0] OP_MOVEOUT = 8'h0C;
   localparam logic [7:0] OP_JUMP    = 8'h0D;
   localparam logic [7:0] OP_EJUMP   = 8'h0E;
   localparam logic [7:0] OP_NEJUMP  = 8'h0F;
   localparam logic [7:0] OP_MTHAN   = 8'h10;
   localparam logic [7:0] OP_WAIT    = 8'h11;
   localparam logic [7:0] OP_INTER   = 8'h12;

   localparam logic [4:0] REG_MD_H   = 5'd26;
   localparam logic [4:0] REG_MD_L   = 5'd27;
   localparam logic [4:0] REG_JUMP_H = 5'd28;
   localparam logic [4:0] REG_JUMP_L = 5'd29;
   localparam logic [4:0] REG_INTER  = 5'd30;

   typedef struct packed {
      logic [7:0]  alu;
      logic [1:0]  pc;
      logic [1:0]  rg;
      logic        imm;
      logic        mem;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  r3;
      logic [4:0]  r4;
      logic [15:0] ram;
      logic [7:0]  imm1;
      logic [7:0]  imm2;
      logic [7:0]  npu_ram;
      logic [4:0]  npu_w;
      logic        illegal;
      logic        hazard;
   } dec_t;

   function automatic logic is_legal(input logic [7:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_RSHIFT,
         OP_LSHIFT, OP_MOVE, OP_MOVEIN, OP_MOVEOUT, OP_JUMP, OP_EJUMP,
         OP_NEJUMP, OP_MTHAN, OP_WAIT, OP_INTER: is_legal = 1'b1;
         default:                                is_legal = 1'b0;
      endcase
   endfunction

   // Pure field decode; hazard is filled in separately.
   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d         = '0;
      d.alu     = w[31:24];
      d.pc      = w[23:22];
      d.rg      = w[21:20];
      d.imm     = w[19];
      d.mem     = w[18];
      d.npu_ram = w[17:10];
      d.npu_w   = w[9:5];
      d.illegal = !is_legal(w[31:24]);
      // Illegal words keep only the raw control fields; operands stay zero.
      if (!d.illegal) begin
         if (w[31:24] == OP_MOVEIN) d.ram = w[17:2];
         if (w[19]) begin
            case (w[31:24])
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_RSHIFT, OP_LSHIFT: begin
                  d.r1   = w[9:5];
                  d.r2   = w[4:0];
                  d.imm1 = w[17:10];
               end
               OP_NOT, OP_MOVE: begin
                  d.r1   = w[9:5];
                  d.imm1 = w[17:10];
               end
               OP_MOVEIN: begin
                  d.imm1 = w[17:10];
                  d.imm2 = w[9:2];
               end
               default: ;
            endcase
         end else begin
            case (w[31:24])
               OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_RSHIFT, OP_LSHIFT,
               OP_MOVEOUT, OP_MTHAN: begin
                  d.r1 = w[17:13];
                  d.r2 = w[12:8];
                  d.r3 = w[7:3];
               end
               OP_DIV: begin
                  d.r1 = w[17:13];
                  d.r2 = w[12:8];
                  d.r3 = REG_MD_H;
                  d.r4 = REG_MD_L;
               end
               OP_EJUMP, OP_NEJUMP: begin
                  d.r1 = w[17:13];
                  d.r2 = w[12:8];
                  d.r3 = REG_JUMP_H;
                  d.r4 = REG_JUMP_L;
               end
               OP_NOT, OP_MOVE, OP_JUMP: begin
                  d.r1 = w[17:13];
                  d.r2 = w[12:8];
               end
               OP_INTER: d.r1 = REG_INTER;
               default: ;
            endcase
         end
      end
      return d;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic             w_push;
   logic             w_pop;
   logic             w_hazard;
   dec_t             w_dec_p0;
   dec_t             w_head;
   dec_t             r_fifo_p1 [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [CNT_W-1:0] r_count;

   assign bus.inst_ready_o = (r_level != FULL_LVL);
   assign bus.dec_valid_o  = (r_level != '0);
   assign w_push = bus.inst_valid_i && bus.inst_ready_o && !bus.flush_i;
   assign w_pop  = bus.dec_valid_o && bus.dec_ready_i;

   // ---- stage p0: combinational decode of the incoming word ----
`ifdef DECODE_HAZARD_EN
   logic [4:0] r_last_dst;
   dec_t       w_raw_p0;

   assign w_raw_p0 = decode(bus.inst_i);
   // A zero last-destination means "none", so a zero source never matches.
   assign w_hazard = ((w_raw_p0.r1 != 5'd0) && (w_raw_p0.r1 == r_last_dst)) ||
                     ((w_raw_p0.r2 != 5'd0) && (w_raw_p0.r2 == r_last_dst));

   always_comb begin
      w_dec_p0        = w_raw_p0;
      w_dec_p0.hazard = w_hazard;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)            r_last_dst <= 5'd0;
      else if (bus.flush_i) r_last_dst <= 5'd0;
      else if (w_push)      r_last_dst <= w_raw_p0.r3;
   end
`else
   assign w_hazard = 1'b0;

   always_comb begin
      w_dec_p0        = decode(bus.inst_i);
      w_dec_p0.hazard = w_hazard;
   end
`endif

   // ---- stage p1: FIFO storage (data, no reset) and control ----
   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo_p1[r_wr_ptr] <= w_dec_p0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_count  <= '0;
      end else begin
         if (bus.flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + 1'b1;
               2'b01:   r_level <= r_level - 1'b1;
               default: ;
            endcase
         end
         if (w_push) r_count <= sat_inc(r_count);
      end
   end

   // ---- output: head entry, zeroed while the FIFO is empty ----
   assign w_head = bus.dec_valid_o ? r_fifo_p1[r_rd_ptr] : '0;

   assign bus.alu_o            = w_head.alu;
   assign bus.pc_o             = w_head.pc;
   assign bus.reg_o            = w_head.rg;
   assign bus.imm_o            = w_head.imm;
   assign bus.mem_o            = w_head.mem;
   assign bus.reg_addr_1_o     = w_head.r1;
   assign bus.reg_addr_2_o     = w_head.r2;
   assign bus.reg_addr_3_o     = w_head.r3;
   assign bus.reg_addr_4_o     = w_head.r4;
   assign bus.ram_addr_o       = w_head.ram;
   assign bus.imm_data_1_o     = w_head.imm1;
   assign bus.imm_data_2_o     = w_head.imm2;
   assign bus.npu_ram_addr_o   = w_head.npu_ram;
   assign bus.npu_w_reg_addr_o = w_head.npu_w;
   assign bus.illegal_o        = w_head.illegal;
   assign bus.hazard_o         = w_head.hazard;
   assign bus.count_o          = r_count;
   assign bus.level_o          = r_level;
endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
// Directed scenarios plus randomized traffic for decode_stage, compared every
// cycle against a queue-based reference model of the decode rules.
// Honours DECODE_HAZARD_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_decode_stage;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int MAXC  = (1 << CNT_W) - 1;

   localparam logic [7:0] OP_ADD     = 8'h01;
   localparam logic [7:0] OP_SUB     = 8'h02;
   localparam logic [7:0] OP_MUL     = 8'h03;
   localparam logic [7:0] OP_DIV     = 8'h04;
   localparam logic [7:0] OP_AND     = 8'h05;
   localparam logic [7:0] OP_OR      = 8'h06;
   localparam logic [7:0] OP_NOT     = 8'h07;
   localparam logic [7:0] OP_RSHIFT  = 8'h08;
   localparam logic [7:0] OP_LSHIFT  = 8'h09;
   localparam logic [7:0] OP_MOVE    = 8'h0A;
   localparam logic [7:0] OP_MOVEIN  = 8'h0B;
   localparam logic [7:0] OP_MOVEOUT = 8'h0C;
   localparam logic [7:0] OP_JUMP    = 8'h0D;
   localparam logic [7:0] OP_EJUMP   = 8'h0E;
   localparam logic [7:0] OP_NEJUMP  = 8'h0F;
   localparam logic [7:0] OP_MTHAN   = 8'h10;
   localparam logic [7:0] OP_WAIT    = 8'h11;
   localparam logic [7:0] OP_INTER   = 8'h12;

`ifdef DECODE_HAZARD_EN
   localparam bit HZ_ON = 1'b1;
`else
   localparam bit HZ_ON = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]  alu;
      logic [1:0]  pc;
      logic [1:0]  rg;
      logic        imm;
      logic        mem;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  r3;
      logic [4:0]  r4;
      logic [15:0] ram;
      logic [7:0]  imm1;
      logic [7:0]  imm2;
      logic [7:0]  npu_ram;
      logic [4:0]  npu_w;
      logic        illegal;
      logic        hazard;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_stage_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
   decode_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   exp_t       q[$];
   int         m_cnt = 0;
   logic [4:0] m_last = 5'd0;
   int         n_chk = 0;
   int         n_pass = 0;
   logic [7:0] legal_ops [18];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
   endtask

   // Field-by-field statement of the decode rules.
   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t       e;
      logic [7:0] op;
      logic       legal;
      op = w[31:24];
      e = '0;
      e.alu = op; e.pc = w[23:22]; e.rg = w[21:20]; e.imm = w[19]; e.mem = w[18];
      e.npu_ram = w[17:10]; e.npu_w = w[9:5];
      legal = op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT,
                         OP_RSHIFT, OP_LSHIFT, OP_MOVE, OP_MOVEIN, OP_MOVEOUT,
                         OP_JUMP, OP_EJUMP, OP_NEJUMP, OP_MTHAN, OP_WAIT, OP_INTER};
      e.illegal = !legal;
      if (!legal) return e;
      if (op == OP_MOVEIN) e.ram = w[17:2];
      if (w[19]) begin
         if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_RSHIFT, OP_LSHIFT, OP_NOT, OP_MOVE})
            e.r1 = w[9:5];
         if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_RSHIFT, OP_LSHIFT})
            e.r2 = w[4:0];
         if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_RSHIFT, OP_LSHIFT, OP_NOT, OP_MOVE, OP_MOVEIN})
            e.imm1 = w[17:10];
         if (op == OP_MOVEIN) e.imm2 = w[9:2];
      end else begin
         if (op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_RSHIFT,
                        OP_LSHIFT, OP_MOVE, OP_MOVEOUT, OP_JUMP, OP_EJUMP, OP_NEJUMP, OP_MTHAN}) begin
            e.r1 = w[17:13];
            e.r2 = w[12:8];
         end
         if (op == OP_INTER) e.r1 = 5'd30;
         if (op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_RSHIFT, OP_LSHIFT, OP_MOVEOUT, OP_MTHAN})
            e.r3 = w[7:3];
         if (op == OP_DIV) begin e.r3 = 5'd26; e.r4 = 5'd27; end
         if (op inside {OP_EJUMP, OP_NEJUMP}) begin e.r3 = 5'd28; e.r4 = 5'd29; end
      end
      return e;
   endfunction

   task automatic model_reset();
      q.delete();
      m_cnt  = 0;
      m_last = 5'd0;
   endtask

   // Applies one clock edge to the model using the inputs held before it.
   task automatic model_edge();
      bit   can_push;
      bit   do_pop;
      exp_t e;
      if (rst) begin
         model_reset();
      end else if (bus.flush_i) begin
         q.delete();
         m_last = 5'd0;
      end else begin
         can_push = bus.inst_valid_i && (q.size() != DEPTH);
         do_pop   = (q.size() != 0) && bus.dec_ready_i;
         if (do_pop) e = q.pop_front();
         if (can_push) begin
            e = ref_decode(bus.inst_i);
            if (HZ_ON)
               e.hazard = ((e.r1 != 0) && (e.r1 == m_last)) || ((e.r2 != 0) && (e.r2 == m_last));
            q.push_back(e);
            m_last = e.r3;
            if (m_cnt != MAXC) m_cnt++;
         end
      end
   endtask

   task automatic check_all();
      exp_t h;
      h = (q.size() != 0) ? q[0] : '0;
      chk("inst_ready", bus.inst_ready_o, q.size() != DEPTH);
      chk("dec_valid", bus.dec_valid_o, q.size() != 0);
      chk("level", bus.level_o, q.size());
      chk("count", bus.count_o, m_cnt);
      chk("fields", {bus.alu_o, bus.pc_o, bus.reg_o, bus.imm_o, bus.mem_o,
                     bus.reg_addr_1_o, bus.reg_addr_2_o, bus.reg_addr_3_o, bus.reg_addr_4_o,
                     bus.ram_addr_o, bus.imm_data_1_o, bus.imm_data_2_o,
                     bus.npu_ram_addr_o, bus.npu_w_reg_addr_o, bus.illegal_o, bus.hazard_o}, h);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   function automatic logic [31:0] mk_r(input logic [7:0] op, input logic [4:0] a,
                                         input logic [4:0] b, input logic [4:0] c);
      return {op, 4'b0, 1'b0, 1'b0, a, b, c, 3'b0};
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom();
      if ($urandom_range(0, 7) == 0) w[31:24] = 8'($urandom_range(0, 255));
      else                           w[31:24] = legal_ops[$urandom_range(0, 17)];
      return w;
   endfunction

   initial begin
      logic [7:0] saved [DEPTH];
      legal_ops = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_RSHIFT,
                    OP_LSHIFT, OP_MOVE, OP_MOVEIN, OP_MOVEOUT, OP_JUMP, OP_EJUMP,
                    OP_NEJUMP, OP_MTHAN, OP_WAIT, OP_INTER};
      bus.flush_i      = 1'b0;
      bus.inst_i       = 32'h0;
      bus.inst_valid_i = 1'b0;
      bus.dec_ready_i  = 1'b1;
      model_reset();

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_all();
      chk("rst_ready", bus.inst_ready_o, 1'b1);
      rst = 1'b0;

      // ADD, register form
      bus.inst_i = mk_r(OP_ADD, 5'd3, 5'd4, 5'd5);
      bus.inst_valid_i = 1'b1;
      tick();
      chk("add_valid", bus.dec_valid_o, 1'b1);
      chk("add_r1", bus.reg_addr_1_o, 5'd3);
      chk("add_r2", bus.reg_addr_2_o, 5'd4);
      chk("add_r3", bus.reg_addr_3_o, 5'd5);
      chk("add_r4", bus.reg_addr_4_o, 5'd0);
      chk("add_illegal", bus.illegal_o, 1'b0);
      chk("add_count", bus.count_o, 1);

      // MOVEIN, immediate form
      bus.inst_i = {OP_MOVEIN, 4'b0, 1'b1, 1'b0, 16'hA5C3, 2'b0};
      tick();
      chk("movein_ram", bus.ram_addr_o, 16'hA5C3);
      chk("movein_imm1", bus.imm_data_1_o, 8'hA5);
      chk("movein_imm2", bus.imm_data_2_o, 8'hC3);
      bus.inst_valid_i = 1'b0;
      tick();

      // Fill past capacity, then drain in order
      bus.dec_ready_i = 1'b0;
      bus.inst_valid_i = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         bus.inst_i = rand_inst();
         if (i < DEPTH) saved[i] = bus.inst_i[31:24];
         tick();
      end
      chk("full_ready", bus.inst_ready_o, 1'b0);
      chk("full_level", bus.level_o, DEPTH);
      chk("full_count", bus.count_o, 2 + DEPTH);
      bus.inst_valid_i = 1'b0;
      bus.dec_ready_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_order", bus.alu_o, saved[i]);
         tick();
      end
      chk("drain_level", bus.level_o, 0);

      // Flush with a concurrent push
      bus.dec_ready_i = 1'b0;
      bus.inst_valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.inst_i = rand_inst();
         tick();
      end
      bus.flush_i = 1'b1;
      bus.inst_i = rand_inst();
      tick();
      chk("flush_valid", bus.dec_valid_o, 1'b0);
      chk("flush_level", bus.level_o, 0);
      chk("flush_ready", bus.inst_ready_o, 1'b1);
      chk("flush_count", bus.count_o, 4 + DEPTH);
      bus.flush_i = 1'b0;

      // Undefined opcode
      bus.inst_i = 32'hFFFF_FFFF;
      tick();
      chk("illegal_flag", bus.illegal_o, 1'b1);
      chk("illegal_regs", {bus.reg_addr_1_o, bus.reg_addr_2_o, bus.reg_addr_3_o, bus.reg_addr_4_o}, 20'h0);
      chk("illegal_ram", bus.ram_addr_o, 16'h0);
      bus.inst_valid_i = 1'b0;
      bus.dec_ready_i = 1'b1;
      tick();

      // RAW hazard, then the same pair separated by a flush
      bus.inst_valid_i = 1'b1;
      bus.inst_i = mk_r(OP_ADD, 5'd1, 5'd2, 5'd7);
      tick();
      bus.inst_i = mk_r(OP_SUB, 5'd7, 5'd3, 5'd4);
      tick();
      chk("hazard_set", bus.hazard_o, HZ_ON);
      bus.inst_i = mk_r(OP_ADD, 5'd1, 5'd2, 5'd7);
      tick();
      bus.inst_valid_i = 1'b0;
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      bus.inst_valid_i = 1'b1;
      bus.inst_i = mk_r(OP_SUB, 5'd7, 5'd3, 5'd4);
      tick();
      chk("hazard_flushed", bus.hazard_o, 1'b0);
      bus.inst_valid_i = 1'b0;
      tick();

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         bus.inst_valid_i = ($urandom_range(0, 3) != 0);
         bus.dec_ready_i  = ($urandom_range(0, 2) != 0);
         bus.flush_i      = ($urandom_range(0, 19) == 0);
         bus.inst_i       = rand_inst();
         tick();
      end
      bus.flush_i = 1'b0;

      // Asynchronous reset in mid-cycle with entries queued
      bus.dec_ready_i = 1'b0;
      bus.inst_valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.inst_i = rand_inst();
         tick();
      end
      bus.inst_valid_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("arst_valid", bus.dec_valid_o, 1'b0);
      chk("arst_level", bus.level_o, 0);
      chk("arst_count", bus.count_o, 0);
      tick();
      rst = 1'b0;
      tick();

      // Counter saturation at full throughput
      bus.dec_ready_i = 1'b1;
      bus.inst_valid_i = 1'b1;
      for (int i = 0; i < MAXC + 40; i++) begin
         bus.inst_i = rand_inst();
         tick();
      end
      chk("count_sat", bus.count_o, MAXC);
      bus.inst_valid_i = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
